reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares the single peripheral register bus (the reg_req_t/reg_rsp_t port feeding the RegMap demux) between NumReq register-bus requesters, e.g. the AXI-to-reg bridge and the debug/ext masters.
- Round-robin arbitration, one outstanding transfer at a time, address pre-decode against RegMap.
- Unmapped addresses are answered locally with an error and never reach the peripheral bus.
- Sits between the requester-side reg bridges and the peripheral demux inside core_v_mcu.

Parameters:
- NumReq, 2, number of requester ports (>=1).
- NumRules, core_v_mcu_pkg::totalRegSlaves (5), entries in AddrMap.
- AddrMap, core_v_mcu_pkg::RegMap, rule_t array; hit when start_addr <= addr < end_addr.
- TimeoutCycles, 256, FWD cycles without ready before abort (used only with REG_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- slv_req_i  in  NumReq x reg_req_t  requester requests (addr, write, wdata, wstrb, valid).
- slv_rsp_o  out  NumReq x reg_rsp_t  requester responses (rdata, error, ready).
- mst_req_o  out  reg_req_t  to peripheral reg demux.
- mst_rsp_i  in  reg_rsp_t  from peripheral reg demux.
- busy_o  out  1  high in any state other than IDLE.
- gnt_idx_o  out  $clog2(NumReq) (min 1)  index of the currently granted requester; 0 in IDLE.
- decode_err_o  out  1  one-cycle pulse on each locally answered unmapped access.
- timeout_o  out  1  one-cycle pulse on timeout abort (tied 0 without the macro).

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE, rr_ptr 0, gnt 0, all outputs 0 (mst_req_o '0, slv_rsp_o '0, busy_o/decode_err_o/timeout_o 0).
- Reset mid-transfer: drops everything immediately; the requester never sees ready for that transfer.
- FSM states: IDLE, FWD, ERR_RSP.
- IDLE:
  - If any slv_req_i[i].valid, pick the first valid index at or after rr_ptr (wrapping modulo NumReq) and register it as gnt.
  - Decode slv_req_i[gnt].addr against AddrMap.
  - Hit -> FWD. Miss -> ERR_RSP.
  - No outputs are driven in this cycle.
- FWD:
  - mst_req_o = slv_req_i[gnt] (combinational pass-through, valid included). All other slv_rsp_o ready=0.
  - When mst_rsp_i.ready: slv_rsp_o[gnt] = mst_rsp_i in the same cycle; rr_ptr <= (gnt+1) mod NumReq; -> IDLE.
- ERR_RSP: drive slv_rsp_o[gnt] = {rdata 0, error 1, ready 1} for exactly one cycle; pulse decode_err_o; rr_ptr advances as in FWD; -> IDLE.
- Latency: 1 arbitration cycle; a zero-wait peripheral completes in 2 cycles. Back-to-back transfers therefore take 2 cycles each.
- Fairness: a requester continuously asserting valid is served within NumReq transfers.
- Simultaneous requests: resolved purely by rr_ptr order. A requester raising valid while another is granted waits for the next IDLE.
- Protocol:
  - Requesters hold valid and payload stable until ready.
  - If the granted valid drops in FWD, mst_req_o.valid drops, no response is given, the FSM returns to IDLE and rr_ptr still advances. A simulation assertion fires on this case.
- Address boundaries: end_addr is exclusive. An address equal to end_addr of one rule and start_addr of the next hits the next rule.
- NumReq=1: rr_ptr is constant 0; behaviour is otherwise identical.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TimeoutCycles+1) clears on entering FWD and increments on each FWD cycle without ready.
  - When it reaches TimeoutCycles-1 without ready: mst_req_o.valid goes 0, slv_rsp_o[gnt] = {rdata 0, error 1, ready 1} for one cycle, timeout_o pulses, -> IDLE, rr_ptr advances.
  - A ready arriving in the same cycle as the timeout wins: normal completion, no timeout.
- Without the macro: no counter, FWD waits indefinitely, timeout_o tied 0.

Decomposition:
- core_v_mcu_pkg additions: reg_arb_state_e enum (IDLE, FWD, ERR_RSP) and RegArbTimeoutCycles default constant.
- reg_req_t, reg_rsp_t and rule_t are reused from core_v_mcu_pkg.
- Sub-module reg_arb_rr_pick: combinational rotate-priority picker (inputs: valid vector, rr_ptr; outputs: gnt index, any_valid). It is reused for a future AXI-side scheduler.

Test Plan:
- Single read: req0 reads 0x50000 (UART) with the peripheral returning ready on its first FWD cycle -> mst_req_o.valid in cycle 1, slv_rsp_o[0].ready with rdata in cycle 1, busy_o high for 1 cycle.
- Contention: req0 and req1 both valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1; each gets exactly 2 of 4 completions in 8 cycles.
- Decode boundary: 0x20FFC -> forwarded to SOC_CTRL. 0x21000 and 0x70000 -> not forwarded, error=1, rdata=0, decode_err_o one pulse each, mst_req_o.valid never high.
- Wait states: peripheral holds ready low 5 cycles -> mst_req_o stable for 6 FWD cycles; req1 arriving meanwhile sees ready=0 until served next.
- Reset mid-FWD: assert rst_ni low during a 10-wait-state access -> all outputs 0 immediately; after release, state IDLE, rr_ptr 0.
- With REG_ARB_TIMEOUT_EN, TimeoutCycles=8, peripheral never ready -> error response and timeout_o pulse on the 8th FWD cycle; a repeat test with ready on the 8th cycle -> normal completion, no timeout.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Register-bus types, the peripheral address map and the arbiter state encoding
// shared by reg_bus_arbiter and its round-robin picker.
package reg_bus_arbiter_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } rule_t;

   localparam int unsigned totalRegSlaves      = 5;
   localparam int unsigned RegArbTimeoutCycles = 256;

   // end_addr is exclusive; UART and GPIO are deliberately adjacent.
   localparam rule_t RegMap [totalRegSlaves] = '{
      '{idx: 32'd0, start_addr: 32'h0001_0000, end_addr: 32'h0001_1000},  // FLL
      '{idx: 32'd1, start_addr: 32'h0002_0000, end_addr: 32'h0002_1000},  // SOC_CTRL
      '{idx: 32'd2, start_addr: 32'h0004_0000, end_addr: 32'h0004_1000},  // EVENT
      '{idx: 32'd3, start_addr: 32'h0005_0000, end_addr: 32'h0005_1000},  // UART
      '{idx: 32'd4, start_addr: 32'h0005_1000, end_addr: 32'h0005_2000}   // GPIO
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      ERR_RSP = 2'd2
   } reg_arb_state_e;

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_FWD     = FWD;
   localparam logic [1:0] ST_ERR_RSP = ERR_RSP;

   localparam reg_rsp_t ErrRsp = '{rdata: 32'h0, error: 1'b1, ready: 1'b1};

   function automatic logic addr_in_rule(input logic [31:0] addr, input rule_t rule);
      return (addr >= rule.start_addr) && (addr < rule.end_addr);
   endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted valid at or after rr_ptr, wrapping modulo NumReq.
module reg_arb_rr_pick #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] valid,
   input  logic [IdxW-1:0]   rr_ptr,
   output logic [IdxW-1:0]   gnt,
   output logic              any_valid
);

   localparam int unsigned SumW = IdxW + 1;

   logic [SumW-1:0] sum;
   logic [IdxW-1:0] idx;

   // rr_ptr and the offset are both below NumReq, so one conditional subtract wraps.
   always_comb begin
      gnt       = '0;
      any_valid = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int off = 0; off < NumReq; off++) begin
         sum = {1'b0, rr_ptr} + SumW'(off);
         if (sum >= SumW'(NumReq)) begin
            sum = sum - SumW'(NumReq);
         end
         idx = sum[IdxW-1:0];
         if (!any_valid && valid[idx]) begin
            any_valid = 1'b1;
            gnt       = idx;
         end
      end
   end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between NumReq requesters,
// with local error answers for unmapped addresses. Optional abort on a stuck peripheral: REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter
   import reg_bus_arbiter_pkg::*;
#(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned NumRules      = totalRegSlaves,
   parameter rule_t       AddrMap [NumRules] = RegMap,
   parameter int unsigned TimeoutCycles = RegArbTimeoutCycles,
   localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  reg_req_t [NumReq-1:0] slv_req_i,
   output reg_rsp_t [NumReq-1:0] slv_rsp_o,
   output reg_req_t              mst_req_o,
   input  reg_rsp_t              mst_rsp_i,
   output logic                  busy_o,
   output logic [IdxW-1:0]       gnt_idx_o,
   output logic                  decode_err_o,
   output logic                  timeout_o
);

   logic [1:0]        state_q, state_d;
   logic [IdxW-1:0]   gnt_q, gnt_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   pick_idx, gnt_next;
   logic [NumReq-1:0] valid_vec;
   logic              any_valid;
   logic              addr_hit;
   logic              tmo_hit;
   reg_req_t          gnt_req;

   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < NumReq; i++) begin
         valid_vec[i] = slv_req_i[i].valid;
      end
   end

   reg_arb_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_rr_pick (
      .valid     (valid_vec),
      .rr_ptr    (rr_ptr_q),
      .gnt       (pick_idx),
      .any_valid (any_valid)
   );

   // Decode the candidate being granted this cycle so the FSM can branch straight to FWD or ERR_RSP.
   always_comb begin
      addr_hit = 1'b0;
      for (int r = 0; r < NumRules; r++) begin
         if (addr_in_rule(slv_req_i[pick_idx].addr, AddrMap[r])) begin
            addr_hit = 1'b1;
         end
      end
   end

   assign gnt_req  = slv_req_i[gnt_q];
   assign gnt_next = (32'(gnt_q) == NumReq - 1) ? '0 : gnt_q + IdxW'(1);

`ifdef REG_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

   logic [CntW-1:0] tmo_cnt_q;

   // A ready in the limit cycle wins, so the abort only fires when ready is still low.
   assign tmo_hit = (state_q == ST_FWD) && gnt_req.valid && !mst_rsp_i.ready &&
                    (tmo_cnt_q == CntW'(TimeoutCycles - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
      end else if (state_q != ST_FWD) begin
         tmo_cnt_q <= '0;
      end else if (!mst_rsp_i.ready) begin
         tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rr_ptr_d     = rr_ptr_q;
      mst_req_o    = '0;
      slv_rsp_o    = '0;
      decode_err_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               gnt_d   = pick_idx;
               state_d = addr_hit ? ST_FWD : ST_ERR_RSP;
            end
         end
         ST_FWD: begin
            mst_req_o = gnt_req;
            if (tmo_hit) begin
               mst_req_o.valid = 1'b0;
            end
            // A withdrawn request is dropped silently but still consumes its round-robin turn.
            if (!gnt_req.valid) begin
               state_d  = ST_IDLE;
               rr_ptr_d = gnt_next;
            end else if (mst_rsp_i.ready) begin
               slv_rsp_o[gnt_q] = mst_rsp_i;
               state_d          = ST_IDLE;
               rr_ptr_d         = gnt_next;
            end else if (tmo_hit) begin
               slv_rsp_o[gnt_q] = ErrRsp;
               state_d          = ST_IDLE;
               rr_ptr_d         = gnt_next;
            end
         end
         ST_ERR_RSP: begin
            slv_rsp_o[gnt_q] = ErrRsp;
            decode_err_o     = 1'b1;
            state_d          = ST_IDLE;
            rr_ptr_d         = gnt_next;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign gnt_idx_o = (state_q == ST_IDLE) ? '0 : gnt_q;
   assign timeout_o = tmo_hit;

   // Requesters must hold valid until ready; a drop mid-transfer is a protocol violation.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ST_FWD) |-> gnt_req.valid);

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (NumReq >= 1) && (TimeoutCycles >= 2));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed steps for reset, decode boundaries, wait states,
// reset mid-transfer, contention and (with REG_ARB_TIMEOUT_EN) timeout, then randomized traffic.
module tb_reg_bus_arbiter;
   import reg_bus_arbiter_pkg::*;

   logic           clk;
   logic           rst_n;
   reg_req_t [1:0] slv_req;
   reg_rsp_t [1:0] slv_rsp;
   reg_req_t       mst_req;
   reg_rsp_t       mst_rsp;
   logic           busy;
   logic [0:0]     gnt_idx;
   logic           decode_err;
   logic           timeout;

   int checks   = 0;
   int failures = 0;

   localparam int W = 35;
   logic [W-1:0] exp_q [$];

   logic [31:0] map_lo [5] = '{32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 32'h0005_0000, 32'h0005_1000};
   logic [31:0] map_hi [5] = '{32'h0001_1000, 32'h0002_1000, 32'h0004_1000, 32'h0005_1000, 32'h0005_2000};
   logic [31:0] bad_addr [6] = '{32'h0000_0000, 32'h0002_1000, 32'h0003_0000, 32'h0005_2000,
                                 32'h0007_0000, 32'hFFFF_FFFC};

   reg_bus_arbiter #(
      .NumReq        (2),
      .TimeoutCycles (8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .slv_req_i    (slv_req),
      .slv_rsp_o    (slv_rsp),
      .mst_req_o    (mst_req),
      .mst_rsp_i    (mst_rsp),
      .busy_o       (busy),
      .gnt_idx_o    (gnt_idx),
      .decode_err_o (decode_err),
      .timeout_o    (timeout)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic reg_req_t mk_req(input logic [31:0] a);
      reg_req_t r;
      r.addr  = a;
      r.write = a[5];
      r.wdata = ~a;
      r.wstrb = 4'hf;
      r.valid = 1'b1;
      return r;
   endfunction

   function automatic logic is_mapped(input logic [31:0] a);
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < 5; r++) begin
         if (a >= map_lo[r] && a < map_hi[r]) hit = 1'b1;
      end
      return hit;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic single_xfer(input int idx, input logic [31:0] addr, input logic hit, input string tag);
      reg_req_t rq;
      reg_rsp_t exp_rsp;
      rq = mk_req(addr);
      exp_rsp = hit ? '{rdata: addr ^ 32'hA5A5_0000, error: 1'b0, ready: 1'b1} : ErrRsp;
      @(posedge clk); #1;
      slv_req[idx] = rq;
      mst_rsp = '{rdata: addr ^ 32'hA5A5_0000, error: 1'b0, ready: 1'b1};
      @(negedge clk);
      check({tag, "_arb_busy"}, 128'(busy), 128'(1'b0));
      check({tag, "_arb_mst_valid"}, 128'(mst_req.valid), 128'(1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_busy"}, 128'(busy), 128'(1'b1));
      check({tag, "_gnt"}, 128'(gnt_idx), 128'(idx));
      check({tag, "_mst_req"}, 128'(mst_req), hit ? 128'(rq) : 128'(0));
      check({tag, "_rsp"}, 128'(slv_rsp[idx]), 128'(exp_rsp));
      check({tag, "_other_rsp"}, 128'(slv_rsp[1-idx]), 128'(0));
      check({tag, "_decode_err"}, 128'(decode_err), 128'(!hit));
      @(posedge clk); #1;
      slv_req[idx] = '0;
      mst_rsp = '0;
      @(negedge clk);
      check({tag, "_done_busy"}, 128'(busy), 128'(1'b0));
      check({tag, "_done_decode_err"}, 128'(decode_err), 128'(1'b0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reg_req_t    rq0, rq1;
      int          exp_ptr, cnt0, cnt1, nready, pick, ptr, wait_left;
      logic        in_xfer;
      logic [1:0]  served;
      logic [W-1:0] got;
      logic [31:0] a;
      logic [31:0] drv_q [2][$];
      logic [31:0] mdl_q [2][$];

      rst_n   = 1'b0;
      slv_req = '0;
      mst_rsp = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_gnt", 128'(gnt_idx), 128'(0));
      check("reset_mst_req", 128'(mst_req), 128'(0));
      check("reset_slv_rsp", 128'(slv_rsp), 128'(0));
      check("reset_decode_err", 128'(decode_err), 128'(0));
      check("reset_timeout", 128'(timeout), 128'(0));

      // Single transfers and decode boundaries.
      single_xfer(0, 32'h0005_0000, 1'b1, "uart_read");
      single_xfer(0, 32'h0002_0FFC, 1'b1, "soc_ctrl_last");
      single_xfer(1, 32'h0002_1000, 1'b0, "soc_ctrl_end");
      single_xfer(0, 32'h0007_0000, 1'b0, "unmapped_70000");
      single_xfer(1, 32'h0005_1000, 1'b1, "gpio_start");

      // Wait states: req0 stalls 5 cycles while req1 queues up behind it.
      rq0 = mk_req(32'h0001_0010);
      rq1 = mk_req(32'h0004_0004);
      @(posedge clk); #1;
      slv_req[0] = rq0;
      mst_rsp = '0;
      for (int w = 0; w < 6; w++) begin
         @(posedge clk); #1;
         if (w == 1) slv_req[1] = rq1;
         if (w == 5) mst_rsp = '{rdata: 32'hBEEF_0001, error: 1'b0, ready: 1'b1};
         @(negedge clk);
         check("wait_mst_stable", 128'(mst_req), 128'(rq0));
         check("wait_req1_blocked", 128'(slv_rsp[1].ready), 128'(0));
         check("wait_no_timeout", 128'(timeout), 128'(0));
         if (w < 5) check("wait_req0_pending", 128'(slv_rsp[0].ready), 128'(0));
         else       check("wait_req0_rsp", 128'(slv_rsp[0]), 128'(34'({32'hBEEF_0001, 1'b0, 1'b1})));
      end
      @(posedge clk); #1;
      slv_req[0] = '0;
      mst_rsp = '{rdata: 32'hCAFE_0002, error: 1'b1, ready: 1'b1};
      @(negedge clk);
      check("wait_gap_busy", 128'(busy), 128'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("wait_req1_gnt", 128'(gnt_idx), 128'(1));
      check("wait_req1_mst", 128'(mst_req), 128'(rq1));
      check("wait_req1_rsp", 128'(slv_rsp[1]), 128'(34'({32'hCAFE_0002, 1'b1, 1'b1})));
      @(posedge clk); #1;
      slv_req[1] = '0;
      mst_rsp = '0;

      // Reset mid-FWD; rr_ptr is 1 just before the reset.
      single_xfer(0, 32'h0005_0020, 1'b1, "pre_reset");
      @(posedge clk); #1;
      slv_req[0] = mk_req(32'h0005_0030);
      mst_rsp = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("midrst_busy_before", 128'(busy), 128'(1));
      check("midrst_valid_before", 128'(mst_req.valid), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_mst_req", 128'(mst_req), 128'(0));
      check("midrst_slv_rsp", 128'(slv_rsp), 128'(0));
      check("midrst_gnt", 128'(gnt_idx), 128'(0));
      slv_req = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_after_busy", 128'(busy), 128'(0));

      // Contention: both valid continuously from rr_ptr 0.
      @(posedge clk); #1;
      slv_req[0] = mk_req(32'h0005_0040);
      slv_req[1] = mk_req(32'h0005_1004);
      mst_rsp = '{rdata: 32'h600D_600D, error: 1'b0, ready: 1'b1};
      exp_ptr = 0;
      cnt0 = 0;
      cnt1 = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (slv_rsp[0].ready === 1'b1) cnt0++;
         if (slv_rsp[1].ready === 1'b1) cnt1++;
         if (c % 2 == 1) begin
            check("cont_busy", 128'(busy), 128'(1));
            check("cont_gnt", 128'(gnt_idx), 128'(exp_ptr));
            exp_ptr = (exp_ptr + 1) % 2;
         end
         @(posedge clk); #1;
      end
      check("cont_count0", 128'(cnt0), 128'(2));
      check("cont_count1", 128'(cnt1), 128'(2));
      slv_req = '0;
      mst_rsp = '0;
      @(posedge clk); #1;

`ifdef REG_ARB_TIMEOUT_EN
      // Peripheral never ready: abort on the 8th FWD cycle.
      slv_req[0] = mk_req(32'h0005_0010);
      mst_rsp = '0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (k < 8) begin
            check("tmo_wait_pulse", 128'(timeout), 128'(0));
            check("tmo_wait_valid", 128'(mst_req.valid), 128'(1));
         end else begin
            check("tmo_pulse", 128'(timeout), 128'(1));
            check("tmo_valid_drop", 128'(mst_req.valid), 128'(0));
            check("tmo_rsp", 128'(slv_rsp[0]), 128'(ErrRsp));
         end
      end
      @(posedge clk); #1;
      slv_req[0] = '0;
      @(posedge clk); #1;
      // Ready arriving on the 8th FWD cycle completes normally.
      slv_req[1] = mk_req(32'h0005_0014);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 8) mst_rsp = '{rdata: 32'h0000_0088, error: 1'b0, ready: 1'b1};
         @(negedge clk);
      end
      check("tmo_race_pulse", 128'(timeout), 128'(0));
      check("tmo_race_rsp", 128'(slv_rsp[1]), 128'(34'({32'h0000_0088, 1'b0, 1'b1})));
      @(posedge clk); #1;
      slv_req = '0;
      mst_rsp = '0;
      @(posedge clk); #1;
`endif

      // Randomized traffic; rr_ptr is 0 here (last completion was req1).
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 20; n++) begin
            int k;
            k = $urandom_range(0, 5);
            if (k < 5) a = map_lo[k] + 32'(4 * $urandom_range(0, (map_hi[k] - map_lo[k]) / 4 - 1));
            else       a = bad_addr[$urandom_range(0, 5)];
            drv_q[i].push_back(a);
         end
         mdl_q[i] = drv_q[i];
      end
      ptr = 0;
      while (mdl_q[0].size() + mdl_q[1].size() > 0) begin
         pick = (mdl_q[ptr].size() > 0) ? ptr : 1 - ptr;
         a = mdl_q[pick].pop_front();
         if (is_mapped(a)) exp_q.push_back({1'(pick), a ^ 32'h5A5A_0000, a[4], 1'b1});
         else              exp_q.push_back({1'(pick), 32'h0, 1'b1, 1'b1});
         ptr = (pick + 1) % 2;
      end

      slv_req[0] = mk_req(drv_q[0][0]);
      slv_req[1] = mk_req(drv_q[1][0]);
      mst_rsp = '0;
      in_xfer = 1'b0;
      wait_left = 0;
      for (int cyc = 0; cyc < 2000 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         nready = 0;
         served = '0;
         got = '0;
         for (int i = 0; i < 2; i++) begin
            if (slv_rsp[i].ready === 1'b1) begin
               nready++;
               served[i] = 1'b1;
               got = {1'(i), slv_rsp[i]};
            end
         end
         if (nready > 0) begin
            check("rand_one_ready", 128'(nready), 128'(1));
            check("rand_rsp_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) check("rand_rsp", 128'(got), 128'(exp_q.pop_front()));
         end
         if (mst_req.valid === 1'b1) check("rand_fwd_mapped", 128'(is_mapped(mst_req.addr)), 128'(1));
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (served[i] && drv_q[i].size() > 0) begin
               void'(drv_q[i].pop_front());
               slv_req[i] = (drv_q[i].size() > 0) ? mk_req(drv_q[i][0]) : '0;
            end
         end
         if (mst_req.valid === 1'b1) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               wait_left = $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
               mst_rsp = '{rdata: mst_req.addr ^ 32'h5A5A_0000, error: mst_req.addr[4], ready: 1'b1};
               in_xfer = 1'b0;
            end else begin
               wait_left--;
               mst_rsp = '0;
            end
         end else begin
            mst_rsp = '0;
         end
      end
      check("rand_drain", 128'(exp_q.size()), 128'(0));
      slv_req = '0;
      mst_rsp = '0;
      repeat (2) @(posedge clk);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
